// File: rtl/trng_osc_ctrl.sv
// Sequencer/sampler for one TRNG oscillator cell: drives T/I1/I2 modes, samples OSC, packs words.
// Optional von Neumann corrector between sampler and packer: define TRNG_VN_EN.
module trng_osc_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int ACC_CYCLES = 16,
    parameter int OUT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             osc_in,
    output logic             t_o,
    output logic             i1_o,
    output logic             i2_o,
    output logic [OUT_W-1:0] rnd_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             busy
);

    localparam int CNT_MAX = (RST_CYCLES > ACC_CYCLES) ? RST_CYCLES : ACC_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(OUT_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRST,
        ST_ARM,
        ST_RUN,
        ST_SAMP,
        ST_HOLD
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    cnt;
    logic             sync1;
    logic             sync2;
    logic [OUT_W-1:0] shift;
    logic [BW-1:0]    bit_cnt;

    logic             full;
    logic             slot_free;
    logic             xfer;
    logic             abort;
    logic             accept;
    logic             acc_bit;
    logic [BW-1:0]    cnt_inc;
    logic             word_done;
    logic [OUT_W-1:0] shift_nxt;

    assign full      = (bit_cnt == BW'(OUT_W));
    assign xfer      = rnd_valid && rnd_ready;
    assign slot_free = !rnd_valid || rnd_ready;
    assign abort     = !en && (state inside {ST_CRST, ST_ARM, ST_RUN});
    assign cnt_inc   = bit_cnt + BW'(1);
    assign word_done = accept && (cnt_inc == BW'(OUT_W));
    assign shift_nxt = {shift[OUT_W-2:0], acc_bit};
    assign i2_o      = 1'b0;

`ifdef TRNG_VN_EN
    // Pair phase: first raw bit of a pair is parked in vn_first, the second decides.
    logic vn_phase;
    logic vn_first;

    assign accept  = (state == ST_SAMP) && vn_phase && (vn_first != sync2);
    assign acc_bit = vn_first;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vn_phase <= 1'b0;
            vn_first <= 1'b0;
        end else if (abort) begin
            vn_phase <= 1'b0;
        end else if (state == ST_SAMP) begin
            vn_phase <= !vn_phase;
            if (!vn_phase) vn_first <= sync2;
        end
    end
`else
    assign accept  = (state == ST_SAMP);
    assign acc_bit = sync2;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (en && !full) next_state = ST_CRST;
            ST_CRST: begin
                if (!en)                               next_state = ST_IDLE;
                else if (cnt == CW'(RST_CYCLES - 1))   next_state = ST_ARM;
            end
            ST_ARM:  next_state = en ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                if (!en)                               next_state = ST_IDLE;
                else if (cnt == CW'(ACC_CYCLES - 1))   next_state = ST_SAMP;
            end
            ST_SAMP: begin
                if (word_done && !slot_free) next_state = ST_HOLD;
                else                         next_state = en ? ST_CRST : ST_IDLE;
            end
            ST_HOLD: if (slot_free) next_state = en ? ST_CRST : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            t_o   <= 1'b0;
            i1_o  <= 1'b0;
            busy  <= 1'b0;
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state)                 cnt <= '0;
            else if (state inside {ST_CRST, ST_RUN}) cnt <= cnt + CW'(1);
            // Mode pins follow the state being entered, so they flip on the entry edge.
            t_o   <= (next_state == ST_RUN);
            i1_o  <= (next_state inside {ST_ARM, ST_RUN});
            busy  <= (next_state != ST_IDLE);
            sync1 <= osc_in;
            sync2 <= sync1;
        end
    end

    // Packer and output slot; a full shift register waits here until the slot frees.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift     <= '0;
            bit_cnt   <= '0;
            rnd_data  <= '0;
            rnd_valid <= 1'b0;
        end else begin
            if (xfer) rnd_valid <= 1'b0;
            if (accept) shift <= shift_nxt;
            if (word_done && slot_free) begin
                rnd_data  <= shift_nxt;
                rnd_valid <= 1'b1;
                bit_cnt   <= '0;
            end else if (accept) begin
                bit_cnt <= cnt_inc;
            end else if (full && slot_free) begin
                rnd_data  <= shift;
                rnd_valid <= 1'b1;
                bit_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_trng_osc_ctrl.sv
// Self-checking bench for trng_osc_ctrl at default parameters; words are scoreboarded through a queue.
module tb_trng_osc_ctrl;

    localparam int PERIOD = 22;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       osc_in;
    logic       t_o;
    logic       i1_o;
    logic       i2_o;
    logic [7:0] rnd_data;
    logic       rnd_valid;
    logic       rnd_ready;
    logic       busy;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];

    trng_osc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .osc_in    (osc_in),
        .t_o       (t_o),
        .i1_o      (i1_o),
        .i2_o      (i2_o),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [63:0] word_bits(input logic [7:0] w0, input logic [7:0] w1);
        logic [63:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            p[i]     = w0[7-i];
            p[8 + i] = w1[7-i];
        end
        return p;
    endfunction

    // Holds osc_in at pat[i] for raw-bit period i; call 1 time unit after the edge en was raised on.
    task automatic drive_bits(input logic [63:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            osc_in = pat[i];
            repeat (PERIOD) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0; en = 1'b0; osc_in = 1'b0; rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic monitor;
        logic       pv = 1'b0;
        logic       pr = 1'b0;
        logic [7:0] pd = '0;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (pv && !pr && rnd_valid) begin
                vectors++;
                if (rnd_data !== pd) begin
                    miscompares++;
                    $display("FAIL hold_stable: rnd_data=%h required %h", rnd_data, pd);
                end
            end
            if (rnd_valid && rnd_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word: rnd_data=%h with no word expected", rnd_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (rnd_data !== exp) begin
                        miscompares++;
                        $display("FAIL word: rnd_data=%h required %h", rnd_data, exp);
                    end
                end
            end
            pv = rnd_valid; pr = rnd_ready; pd = rnd_data;
        end
    endtask

    task automatic test_reset;
        int bad = 0;
        rst_n = 1'b0; en = 1'b0; osc_in = 1'b0; rnd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({t_o, i1_o, i2_o, busy, rnd_valid, rnd_data} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_state: outputs=%h required 0", {t_o, i1_o, i2_o, busy, rnd_valid, rnd_data});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if ({t_o, i1_o, i2_o, busy, rnd_valid} !== 5'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL idle_en0: %0d cycles left idle, required 0", bad);
        end
    endtask

    task automatic test_mode_seq;
        logic [3:0] exp;
        int         ph;
        do_reset();
        rnd_ready = 1'b1;
        en = 1'b1;
        for (int c = 1; c <= 2 * PERIOD; c++) begin
            @(posedge clk); #1;
            ph = (c - 1) % PERIOD;
            if (ph < 4)       exp = 4'b0001;
            else if (ph == 4) exp = 4'b0101;
            else if (ph < 21) exp = 4'b1101;
            else              exp = 4'b0001;
            vectors++;
            if ({t_o, i1_o, i2_o, busy} !== exp) begin
                miscompares++;
                $display("FAIL mode_seq c=%0d: {t,i1,i2,busy}=%b required %b", c, {t_o, i1_o, i2_o, busy}, exp);
            end
        end
        en = 1'b0;
        @(posedge clk); #1;
    endtask

`ifndef TRNG_VN_EN
    task automatic test_pack;
        do_reset();
        rnd_ready = 1'b1;
        exp_q.push_back(8'hF0);
        en = 1'b1;
        drive_bits(word_bits(8'hF0, 8'h00), 8);
        vectors++;
        if (rnd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pack_early: rnd_valid=%b at edge 176 required 0", rnd_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if ({rnd_valid, rnd_data} !== {1'b1, 8'hF0}) begin
            miscompares++;
            $display("FAIL pack_edge177: valid,data=%b,%h required 1,f0", rnd_valid, rnd_data);
        end
        en = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({rnd_valid, busy, exp_q.size() == 0} !== 3'b001) begin
            miscompares++;
            $display("FAIL pack_drain: valid,busy,q_empty=%b required 001", {rnd_valid, busy, exp_q.size() == 0});
        end
    endtask

    task automatic test_abort;
        int bad = 0;
        do_reset();
        rnd_ready = 1'b1;
        exp_q.push_back(8'hB3);
        en = 1'b1;
        drive_bits(64'h1, 2);
        osc_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if ({t_o, i1_o} !== 2'b11) begin
            miscompares++;
            $display("FAIL abort_in_run: {t,i1}=%b required 11", {t_o, i1_o});
        end
        en = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({t_o, i1_o, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_idle: {t,i1,busy}=%b required 000", {t_o, i1_o, busy});
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if ({busy, rnd_valid} !== 2'b00) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL abort_stay: %0d active cycles, required 0", bad);
        end
        en = 1'b1;
        drive_bits(64'h33, 6);
        vectors++;
        if (rnd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_early: rnd_valid=%b required 0", rnd_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if ({rnd_valid, rnd_data} !== {1'b1, 8'hB3}) begin
            miscompares++;
            $display("FAIL abort_word: valid,data=%b,%h required 1,b3", rnd_valid, rnd_data);
        end
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_drain: %0d words pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        int bad = 0;
        do_reset();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        en = 1'b1;
        drive_bits(word_bits(8'hA5, 8'h3C), 16);
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 20; c++) begin
            if ({t_o, i1_o, i2_o, busy, rnd_valid, rnd_data} !== {5'b00011, 8'hA5}) bad++;
            @(posedge clk); #1;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL hold_state: %0d cycles off, required 0", bad);
        end
        rnd_ready = 1'b1;
        @(posedge clk); #1;
        rnd_ready = 1'b0;
        vectors++;
        if ({rnd_valid, rnd_data} !== {1'b1, 8'h3C}) begin
            miscompares++;
            $display("FAIL back_to_back: valid,data=%b,%h required 1,3c", rnd_valid, rnd_data);
        end
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if ({t_o, i1_o, busy} !== 3'b011) begin
            miscompares++;
            $display("FAIL resume_arm: {t,i1,busy}=%b required 011", {t_o, i1_o, busy});
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({t_o, rnd_valid, exp_q.size() == 1} !== 3'b111) begin
            miscompares++;
            $display("FAIL resume_run: t,valid,one_pending=%b required 111", {t_o, rnd_valid, exp_q.size() == 1});
        end
        rst_n = 1'b0;
        en = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({t_o, i1_o, i2_o, busy, rnd_valid, rnd_data} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_mid_run: outputs=%h required 0", {t_o, i1_o, i2_o, busy, rnd_valid, rnd_data});
        end
        rst_n = 1'b1;
        exp_q.delete();
    endtask
`else
    task automatic test_vn;
        logic [63:0] pat = '0;
        int          bad = 0;
        for (int i = 0; i < 24; i++) pat[i] = ((i % 6) inside {0, 2, 3, 5});
        do_reset();
        rnd_ready = 1'b1;
        exp_q.push_back(8'hAA);
        en = 1'b1;
        drive_bits(pat, 24);
        vectors++;
        if (rnd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL vn_early: rnd_valid=%b required 0", rnd_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if ({rnd_valid, rnd_data} !== {1'b1, 8'hAA}) begin
            miscompares++;
            $display("FAIL vn_word: valid,data=%b,%h required 1,aa", rnd_valid, rnd_data);
        end
        do_reset();
        rnd_ready = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 24 * PERIOD; i++) begin
            osc_in = 1'b1;
            @(posedge clk); #1;
            if (rnd_valid !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL vn_const: rnd_valid high %0d cycles, required 0", bad);
        end
        en = 1'b0;
        exp_q.delete();
    endtask
`endif

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_mode_seq();
`ifndef TRNG_VN_EN
        test_pack();
        test_abort();
        test_back_to_back();
`else
        test_vn();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trng_osc_ctrl.md
# trng_osc_ctrl

Sequencer and sampler for a single TRNG oscillator cell. Drives the cell's T/I1/I2 mode inputs through reset → arm → oscillate phases, synchronizes and samples the cell's asynchronous OSC output, and packs the sampled bits into OUT_W-bit words. Words are delivered through a valid/ready handshake. It sits between the oscillator cell and the entropy consumer (health test / FIFO).

## Interface
Parameters:
- RST_CYCLES, 4: cycles the cell is held in reset mode per raw bit (≥1).
- ACC_CYCLES, 16: cycles the cell oscillates before sampling (≥1); jitter accumulation time.
- OUT_W, 8: output word width (≥2).

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  run enable; level-sensitive.
- osc_in  in  1  OSC output of the cell; asynchronous to clk.
- t_o  out  1  cell T input.
- i1_o  out  1  cell I1 input.
- i2_o  out  1  cell I2 input.
- rnd_data  out  OUT_W  output word; stable while rnd_valid=1.
- rnd_valid  out  1  word available.
- rnd_ready  in  1  consumer accepts word.
- busy  out  1  FSM not in IDLE.

## Operation
- Cell modes driven as registered outputs: RESET {t,i1,i2}=000; ARM 010; RUN 110; i2_o is always 0.
- osc_in passes through a 2-FF synchronizer; only the second flop is sampled.
- FSM states:
  - IDLE: mode RESET. Go to CRST when en=1 and the shift register is not full.
  - CRST: mode RESET for RST_CYCLES cycles, then ARM.
  - ARM: mode ARM for 1 cycle, then RUN.
  - RUN: mode RUN for ACC_CYCLES cycles, then SAMP.
  - SAMP: mode RESET. Capture the synchronized bit as a raw bit. Go to HOLD if the shift register becomes full while the output is occupied; else go to CRST if en=1, or IDLE if en=0.
  - HOLD: mode RESET. Wait until the output slot frees, then go to CRST if en=1, or IDLE if en=0.
- en=0 in CRST/ARM/RUN: return to IDLE on the next edge. The partial raw bit is dropped. Shift register contents and any pending output word are retained.
- Packing is MSB-first: shift <= {shift[OUT_W-2:0], bit}. bit_cnt counts accepted bits, 0..OUT_W.
- When bit_cnt reaches OUT_W:
  - If the output slot is empty, or is being drained on this same edge: load rnd_data, set rnd_valid, clear bit_cnt.
  - Otherwise the word is held as full until the slot frees.
- Handshake:
  - Transfer occurs on an edge where rnd_valid=1 and rnd_ready=1.
  - rnd_data must not change while rnd_valid=1 without a transfer.
  - rnd_ready is ignored while rnd_valid=0.
  - After a transfer, rnd_valid drops the next cycle unless a new word loads on the same edge; back-to-back is allowed and rnd_valid stays 1.
- Reset (including mid-operation): state=IDLE; t_o=i1_o=i2_o=0; rnd_valid=0; rnd_data=0; busy=0; bit_cnt=0; shift=0; synchronizer=0.

## Timing
- Raw bit period: RST_CYCLES+1+ACC_CYCLES+1 cycles (22 at defaults), measured from CRST entry to SAMP.
- First CRST cycle occurs on the edge after en is seen high in IDLE.
- Sampled value is osc_in as seen 2 edges before SAMP (synchronizer latency).
- rnd_valid rises on the edge after the SAMP that completes a word.
- Mode outputs change on the edge of state entry, with no combinational path from en.
- busy is registered and equals (state != IDLE).

## Configuration
- TRNG_VN_EN defined: von Neumann corrector between sampler and packer.
  - Raw bits are consumed in pairs (first, second): 01→0, 10→1, 00/11 → no output bit.
  - A pair-phase flag toggles per raw bit; it is cleared by reset and by the en=0 abort.
  - An output word needs 2·OUT_W raw bits minimum.
- TRNG_VN_EN undefined: every raw bit goes straight to the packer; no pair logic is instantiated.

## Test plan
- Reset/idle: assert rst_n=0 mid-RUN with rnd_valid=1 → next cycle all outputs 0, state IDLE; with en=0, modes stay 000 indefinitely.
- Mode sequence at defaults: en=1 → {t,i1,i2} shows 000 for 4 cycles, 010 for 1 cycle, 110 for 16 cycles, then 000 at SAMP; repeats every 22 cycles.
- Packing, VN off: osc_in held at 1 for first 4 samples and 0 for last 4 → rnd_data=8'hF0, rnd_valid rises 1 cycle after the 8th SAMP (edge 177 after en).
- Backpressure: rnd_ready=0 throughout → first word held stable; second word fills and FSM sits in HOLD with modes 000. Raise rnd_ready for 1 cycle → first word transfers, second loads back-to-back with rnd_valid staying 1, and sampling resumes.
- VN on: osc_in pattern per sample 1,0,1,1,0,1 repeating → pairs 10→1, 11 drop, 01→0 → rnd_data=8'hAA after 24 raw bits; osc_in constant 1 → rnd_valid never asserts.
- Abort: drop en during RUN of the 3rd raw bit → IDLE next edge, bit_cnt stays 2. Re-assert en → word completes after 6 more raw bits.
